// File: rtl/lc3b_types.sv
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b word/line typedefs and the memory-arbiter state
//               encoding used by cache_arbiter and cache_arbiter_mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter_mux.sv
// ============================================================================
// Module      : cache_arbiter_mux
// Description : Combinational steering of request fields toward memory and of
//               pmem_resp/pmem_rdata back to the granted cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter_mux
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  arb_state_t        grant,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_rdata = '0;

        case (grant)
            ARB_SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_write   = i_pmem_write;
                pmem_address = i_pmem_address;
                pmem_wdata   = i_pmem_wdata;
                i_pmem_resp  = pmem_resp;
                i_pmem_rdata = pmem_rdata;
                d_pmem_rdata = pmem_rdata;
            end
            ARB_SERVE_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                i_pmem_rdata = pmem_rdata;
                d_pmem_rdata = pmem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// Module      : cache_arbiter
// Description : Shares one physical-memory port between the I-cache and
//               D-cache controllers; grant held until pmem_resp, then one IDLE
//               cycle before re-arbitration. D wins ties by default; defining
//               CACHE_ARBITER_RR_EN alternates ties via a last-grant pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_t r_state;
    arb_state_t w_grant;
    logic       w_i_req;
    logic       w_d_req;

`ifdef CACHE_ARBITER_RR_EN
    // Set when the most recent grant went to D; reset clear so D wins first tie.
    logic       r_last_d;
`endif

    assign w_i_req = i_pmem_read | i_pmem_write;
    assign w_d_req = d_pmem_read | d_pmem_write;

    // Grant is masked during rst so an abandoned transaction drops immediately.
    assign w_grant = rst ? ARB_IDLE : r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
`ifdef CACHE_ARBITER_RR_EN
            r_last_d <= 1'b0;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
`ifdef CACHE_ARBITER_RR_EN
                    if (w_d_req && (!w_i_req || !r_last_d)) begin
                        r_state  <= ARB_SERVE_D;
                        r_last_d <= 1'b1;
                    end else if (w_i_req) begin
                        r_state  <= ARB_SERVE_I;
                        r_last_d <= 1'b0;
                    end
`else
                    if (w_d_req) begin
                        r_state <= ARB_SERVE_D;
                    end else if (w_i_req) begin
                        r_state <= ARB_SERVE_I;
                    end
`endif
                end
                ARB_SERVE_I, ARB_SERVE_D: begin
                    if (pmem_resp) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    cache_arbiter_mux #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_mux (
        .grant          (w_grant),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_address (i_pmem_address),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Self-checking bench for cache_arbiter: directed scenarios plus
//               randomized traffic against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_pmem_read, i_pmem_write, i_pmem_resp;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_wdata, i_pmem_rdata;
    logic              d_pmem_read, d_pmem_write, d_pmem_resp;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata, d_pmem_rdata;
    logic              pmem_read, pmem_write, pmem_resp;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata, pmem_rdata;

    int   errors = 0;
    int   checks = 0;
    logic s_act, s_resp;
    int   mem_run;
    logic model_last_d;

    cache_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_address (i_pmem_address),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        s_act  = pmem_read | pmem_write;
        s_resp = pmem_resp;
        if (s_act) mem_run = s_resp ? 0 : mem_run + 1;
    endtask

    // Memory answers in the lat-th cycle of each transaction.
    task automatic mem_drive(input int lat);
        pmem_resp = s_act && !s_resp && (mem_run == lat - 1);
    endtask

    task automatic idle_inputs();
        i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_pmem_address = '0; i_pmem_wdata = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) cyc();
        rst = 1'b0;
        model_last_d = 1'b0;
        mem_run = 0;
        s_act = 1'b0;
        s_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        i_pmem_read = 1'b1;  i_pmem_address = 16'h0100; i_pmem_wdata = rand_line();
        d_pmem_write = 1'b1; d_pmem_address = 16'h8200; d_pmem_wdata = rand_line();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got rd=%b wr=%b iresp=%b dresp=%b addr=%h expected all zero",
                         pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address);
            end
            cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, pmem_address} !== '0) begin
            errors++;
            $display("FAIL first_idle: got rd=%b wr=%b addr=%h expected 0 0 0000", pmem_read, pmem_write, pmem_address);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {1'b0, 1'b1, 16'h8200, d_pmem_wdata}) begin
            errors++;
            $display("FAIL reset_then_serve_d: got rd=%b wr=%b addr=%h expected 0 1 8200", pmem_read, pmem_write, pmem_address);
        end
        do_reset();
    endtask

    task automatic test_lone_i();
        int   rd_cnt = 0;
        int   ir = 0;
        int   dr = 0;
        int   first = -1;
        logic got_i;
        logic [LINE_W-1:0] exp_rd;
        exp_rd = {16{8'hA5}};
        i_pmem_read = 1'b1; i_pmem_address = 16'h1230; pmem_rdata = exp_rd;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (pmem_read) begin
                rd_cnt++;
                if (first < 0) first = c;
            end
            got_i = i_pmem_resp;
            if (i_pmem_resp) begin
                ir++;
                checks++;
                if (i_pmem_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL lone_i_rdata: got %h expected %h", i_pmem_rdata, exp_rd);
                end
            end
            if (d_pmem_resp) dr++;
            cyc();
            if (got_i) i_pmem_read = 1'b0;
            mem_drive(4);
        end
        checks++;
        if (first != 1) begin errors++; $display("FAIL lone_i_latency: got first active cycle %0d expected 1", first); end
        checks++;
        if (rd_cnt != 4) begin errors++; $display("FAIL lone_i_read_cycles: got %0d expected 4", rd_cnt); end
        checks++;
        if (ir != 1) begin errors++; $display("FAIL lone_i_resp_pulses: got %0d expected 1", ir); end
        checks++;
        if (dr != 0) begin errors++; $display("FAIL lone_i_d_resp: got %0d pulses expected 0", dr); end
        do_reset();
    endtask

    task automatic test_priority();
        logic got_i, got_d;
        logic [LINE_W-1:0] d_line;
        d_line = {8{16'h1111}};
        i_pmem_read = 1'b1;  i_pmem_address = 16'h0040; i_pmem_wdata = rand_line();
        d_pmem_write = 1'b1; d_pmem_address = 16'h8000; d_pmem_wdata = d_line;
        pmem_rdata = rand_line();
        for (int c = 0; c < 8; c++) begin
            sample();
            if (c == 1) begin
                checks++;
                if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {1'b0, 1'b1, 16'h8000, d_line}) begin
                    errors++;
                    $display("FAIL prio_d_first: got rd=%b wr=%b addr=%h wdata=%h expected 0 1 8000 %h",
                             pmem_read, pmem_write, pmem_address, pmem_wdata, d_line);
                end
            end
            if (c == 2) begin
                checks++;
                if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin
                    errors++; $display("FAIL prio_d_resp: got i=%b d=%b expected 0 1", i_pmem_resp, d_pmem_resp);
                end
            end
            if (c == 3) begin
                checks++;
                if ({pmem_read, pmem_write} !== 2'b00) begin
                    errors++; $display("FAIL prio_gap: got rd=%b wr=%b expected 0 0", pmem_read, pmem_write);
                end
            end
            if (c == 4) begin
                checks++;
                if ({pmem_read, pmem_write, pmem_address} !== {1'b1, 1'b0, 16'h0040}) begin
                    errors++; $display("FAIL prio_i_second: got rd=%b wr=%b addr=%h expected 1 0 0040", pmem_read, pmem_write, pmem_address);
                end
            end
            if (c == 5) begin
                checks++;
                if ({i_pmem_resp, d_pmem_resp, i_pmem_rdata} !== {1'b1, 1'b0, pmem_rdata}) begin
                    errors++; $display("FAIL prio_i_resp: got i=%b d=%b rdata=%h expected 1 0 %h",
                                       i_pmem_resp, d_pmem_resp, i_pmem_rdata, pmem_rdata);
                end
            end
            got_i = i_pmem_resp;
            got_d = d_pmem_resp;
            cyc();
            if (got_i) i_pmem_read = 1'b0;
            if (got_d) d_pmem_write = 1'b0;
            mem_drive(2);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        int   nresp = 0;
        int   ir = 0;
        logic got_d;
        d_pmem_write = 1'b1; d_pmem_address = 16'h8000; d_pmem_wdata = rand_line();
        for (int c = 0; c < 9; c++) begin
            sample();
            if (c == 2) begin
                checks++;
                if ({d_pmem_resp, pmem_write} !== 2'b11) begin
                    errors++; $display("FAIL b2b_write_resp: got resp=%b wr=%b expected 1 1", d_pmem_resp, pmem_write);
                end
            end
            if (c == 3) begin
                checks++;
                if ({pmem_read, pmem_write} !== 2'b00) begin
                    errors++; $display("FAIL b2b_gap: got rd=%b wr=%b expected 0 0", pmem_read, pmem_write);
                end
            end
            if (c == 4) begin
                checks++;
                if ({pmem_read, pmem_write, pmem_address} !== {1'b1, 1'b0, 16'h8010}) begin
                    errors++; $display("FAIL b2b_fill: got rd=%b wr=%b addr=%h expected 1 0 8010", pmem_read, pmem_write, pmem_address);
                end
            end
            if (d_pmem_resp) nresp++;
            if (i_pmem_resp) ir++;
            got_d = d_pmem_resp;
            cyc();
            if (got_d) begin
                if (d_pmem_write) begin
                    d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 16'h8010;
                end else begin
                    d_pmem_read = 1'b0;
                end
            end
            mem_drive(2);
        end
        checks++;
        if (nresp != 2) begin errors++; $display("FAIL b2b_resp_count: got %0d expected 2", nresp); end
        checks++;
        if (ir != 0) begin errors++; $display("FAIL b2b_i_resp: got %0d expected 0", ir); end
        do_reset();
    endtask

    task automatic test_order();
        int   g = 0;
        int   i_n = 0;
        int   d_n = 0;
        logic prev = 1'b0;
        logic got_i, got_d;
        logic [3:0] order = 4'b0000;
        logic [3:0] exp_order;
`ifdef CACHE_ARBITER_RR_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
        d_pmem_read = 1'b1; d_pmem_address = 16'h8100;
        for (int c = 0; c < 40 && g < 4; c++) begin
            sample();
            if (s_act && !prev) begin
                order[g] = pmem_address[15];
                g++;
            end
            prev = s_act;
            got_i = i_pmem_resp;
            got_d = d_pmem_resp;
            cyc();
            if (got_i) begin i_n++; i_pmem_address = 16'h0100 + 16'(16 * i_n); end
            if (got_d) begin d_n++; d_pmem_address = 16'h8100 + 16'(16 * d_n); end
            mem_drive(2);
        end
        checks++;
        if (g != 4) begin errors++; $display("FAIL order_grant_count: got %0d expected 4", g); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (order[k] !== exp_order[k]) begin
                errors++;
                $display("FAIL order_grant_%0d: got is_d=%b expected is_d=%b", k, order[k], exp_order[k]);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        i_pmem_read = 1'b1; i_pmem_address = 16'h2000;
        pmem_rdata = rand_line();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (pmem_read !== 1'b1) begin errors++; $display("FAIL rstmid_serving: got rd=%b expected 1", pmem_read); end
            end
            if (c >= 2) begin
                checks++;
                if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
                    errors++;
                    $display("FAIL rstmid_cycle%0d: got rd=%b wr=%b iresp=%b dresp=%b expected 0 0 0 0",
                             c, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
                end
            end
            cyc();
            rst = (c == 1);
            if (c == 1) i_pmem_read = 1'b0;
            pmem_resp = (c == 3);
        end
        do_reset();
    endtask

    // Reference: grants follow the previous cycle's requests when memory was idle,
    // a granted owner keeps memory until resp, and every resp is followed by one idle cycle.
    task automatic test_random();
        logic busy = 1'b0, owner_d = 1'b0, i_done = 1'b0, d_done = 1'b0;
        logic p_act = 1'b0, p_resp = 1'b0, p_i = 1'b0, p_d = 1'b0;
        logic exp_act, exp_d, is_new;
        logic [1:0] exp_resp;
        logic [ADDR_W+LINE_W+1:0] exp_bus;
        int left = 0;
        for (int k = 0; k < 600; k++) begin
            pmem_resp = 1'b0;
            if (busy) begin
                left--;
                if (left == 0) begin pmem_resp = 1'b1; pmem_rdata = rand_line(); end
            end
            if (i_done) begin i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_done = 1'b0; end
            if (!(i_pmem_read || i_pmem_write) && $urandom_range(0, 2) == 0) begin
                i_pmem_read = 1'($urandom_range(0, 1)); i_pmem_write = !i_pmem_read;
                i_pmem_address = {1'b0, 15'($urandom)}; i_pmem_wdata = rand_line();
            end
            if (d_done) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_done = 1'b0; end
            if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 2) == 0) begin
                d_pmem_read = 1'($urandom_range(0, 1)); d_pmem_write = !d_pmem_read;
                d_pmem_address = {1'b1, 15'($urandom)}; d_pmem_wdata = rand_line();
            end
            @(negedge clk);
            is_new = 1'b0;
            if (p_act) begin
                exp_act = !p_resp; exp_d = owner_d;
            end else if (p_i || p_d) begin
                exp_act = 1'b1; is_new = 1'b1;
                if (p_i && p_d) begin
`ifdef CACHE_ARBITER_RR_EN
                    exp_d = !model_last_d;
`else
                    exp_d = 1'b1;
`endif
                end else begin
                    exp_d = p_d;
                end
            end else begin
                exp_act = 1'b0; exp_d = owner_d;
            end
            if (!exp_act)   exp_bus = '0;
            else if (exp_d) exp_bus = {d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata};
            else            exp_bus = {i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata};
            exp_resp = !exp_act ? 2'b00 : (exp_d ? {1'b0, pmem_resp} : {pmem_resp, 1'b0});
            checks++;
            if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== exp_bus) begin
                errors++;
                $display("FAIL rand_mem_bus cyc%0d: got rd=%b wr=%b addr=%h expected rd=%b wr=%b addr=%h",
                         k, pmem_read, pmem_write, pmem_address,
                         exp_bus[ADDR_W+LINE_W+1], exp_bus[ADDR_W+LINE_W], exp_bus[ADDR_W+LINE_W-1:LINE_W]);
            end
            checks++;
            if ({i_pmem_resp, d_pmem_resp} !== exp_resp) begin
                errors++;
                $display("FAIL rand_resp cyc%0d: got i=%b d=%b expected i=%b d=%b",
                         k, i_pmem_resp, d_pmem_resp, exp_resp[1], exp_resp[0]);
            end
            if (exp_act) begin
                checks++;
                if ({i_pmem_rdata, d_pmem_rdata} !== {pmem_rdata, pmem_rdata}) begin
                    errors++;
                    $display("FAIL rand_rdata cyc%0d: got i=%h d=%h expected %h", k, i_pmem_rdata, d_pmem_rdata, pmem_rdata);
                end
            end
            if (is_new) begin
                model_last_d = exp_d; owner_d = exp_d; busy = 1'b1;
                left = $urandom_range(1, 4);
            end
            if (exp_act && pmem_resp) begin
                busy = 1'b0;
                if (owner_d) d_done = 1'b1; else i_done = 1'b1;
            end
            p_act  = exp_act;
            p_resp = pmem_resp;
            p_i    = i_pmem_read | i_pmem_write;
            p_d    = d_pmem_read | d_pmem_write;
            @(posedge clk);
            #1;
        end
        do_reset();
    endtask

    initial begin
        idle_inputs();
        model_last_d = 1'b0;
        mem_run = 0;
        s_act = 1'b0;
        s_resp = 1'b0;
        test_reset();
        test_lone_i();
        test_priority();
        test_back_to_back();
        test_order();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
